// File: rtl/stage_monitor_if.sv
// Event drain port of stage_monitor: FIFO head, pop handshake and sticky overflow.
interface stage_monitor_if #(parameter int DW = 9);
  logic          evt_valid_o;
  logic          evt_ready_i;
  logic [DW-1:0] evt_data_o;
  logic          evt_overflow_o;

  modport master (output evt_valid_o, evt_data_o, evt_overflow_o, input evt_ready_i);
  modport slave  (input evt_valid_o, evt_data_o, evt_overflow_o, output evt_ready_i);
endinterface

// File: rtl/stage_monitor.sv
// stage_monitor: per-channel test-stage tracker (IDLE/RUN/PASS/FAIL/TIMEOUT)
// sampled on a prescaled strobe, with an optional stage-change event FIFO.
// Optional feature macro: STAGE_MONITOR_LOG_EN (pending logic + event FIFO).

// One monitored channel: state, last sampled code and the RUN timer.
module stage_monitor_ch #(
  parameter int              SW         = 8,
  parameter int              TIMEOUT    = 24000,
  parameter logic [SW-1:0]   START_CODE = 8'hFF,
  parameter logic [SW-1:0]   PASS_CODE  = 8'hFE
) (
  input  logic          clock,
  input  logic          resetb,
  input  logic          clr,
  input  logic          strobe,
  input  logic [SW-1:0] s,
  input  logic          err,
  output logic [2:0]    state,
  output logic          chg
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE = 3'd0, RUN = 3'd1, PASS = 3'd2, FAIL = 3'd3, TMO = 3'd4} st_e;

  st_e           st;
  logic [SW-1:0] last;
  logic [TW-1:0] timer, timer_nx;

  assign timer_nx = timer + 1'b1;
  assign chg      = strobe && (s != last);
  assign state    = st;

  // Stage tracking, evaluated only on the sample strobe; terminal states hold.
  always_ff @(posedge clock) begin
    if (!resetb || clr) begin
      st    <= IDLE;
      last  <= '0;
      timer <= '0;
    end else if (strobe) begin
      last <= s;
      unique case (st)
        IDLE: if (s == START_CODE) begin
          st    <= RUN;
          timer <= '0;
        end
        RUN: begin
          if (err)                 st <= FAIL;
          else if (s == PASS_CODE) st <= PASS;
          else if (s != last)      timer <= '0;
          else begin
            timer <= timer_nx;
            if (timer_nx == TW'(TIMEOUT)) st <= TMO;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

module stage_monitor #(
  parameter int            NCH        = 2,
  parameter int            SW         = 8,
  parameter int            SAMPLE     = 100,
  parameter int            TIMEOUT    = 24000,
  parameter logic [SW-1:0] START_CODE = 8'hFF,
  parameter logic [SW-1:0] PASS_CODE  = 8'hFE,
  parameter int            DEPTH      = 8
) (
  input  logic              clock,
  input  logic              resetb,
  input  logic [NCH*SW-1:0] stage_i,
  input  logic [NCH-1:0]    err_i,
  input  logic              clr_i,
  output logic [NCH*3-1:0]  ch_state_o,
  output logic              all_done_o,
  output logic              all_pass_o,
  stage_monitor_if.master   evt
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int DW = CW + SW;
  localparam int PW = (SAMPLE > 1) ? $clog2(SAMPLE) : 1;

  logic [PW-1:0]  presc;
  logic           strobe;
  logic [NCH-1:0] chg;

  assign strobe = (presc == PW'(SAMPLE - 1));

  // Free-running sample prescaler, 0..SAMPLE-1.
  always_ff @(posedge clock) begin
    if (!resetb || clr_i) presc <= '0;
    else                  presc <= strobe ? '0 : presc + 1'b1;
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    stage_monitor_ch #(
      .SW(SW), .TIMEOUT(TIMEOUT), .START_CODE(START_CODE), .PASS_CODE(PASS_CODE)
    ) u_ch (
      .clock (clock),
      .resetb(resetb),
      .clr   (clr_i),
      .strobe(strobe),
      .s     (stage_i[k*SW +: SW]),
      .err   (err_i[k]),
      .state (ch_state_o[k*3 +: 3]),
      .chg   (chg[k])
    );
  end

  // Summary flags decoded straight from the channel state registers.
  always_comb begin
    all_done_o = 1'b1;
    all_pass_o = 1'b1;
    for (int k = 0; k < NCH; k++) begin
      if (ch_state_o[k*3 +: 3] < 3'd2)  all_done_o = 1'b0;
      if (ch_state_o[k*3 +: 3] != 3'd2) all_pass_o = 1'b0;
    end
  end

`ifdef STAGE_MONITOR_LOG_EN
  localparam int AW = $clog2(DEPTH);

  logic [NCH-1:0]         pend, pick;
  logic [NCH-1:0][SW-1:0] pend_s;
  logic                   push, wr, pop, empty, full, ovf;
  logic [DW-1:0]          push_d;
  logic [DW-1:0]          mem [DEPTH];
  logic [AW:0]            wr_ptr, rd_ptr;

  // Lowest-index pending channel wins the single push slot each cycle.
  always_comb begin
    push   = 1'b0;
    push_d = '0;
    pick   = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (pend[k]) begin
        push    = 1'b1;
        push_d  = {CW'(k), pend_s[k]};
        pick    = '0;
        pick[k] = 1'b1;
      end
    end
  end

  // Pending bits: set on a stage change at the strobe, cleared once pushed.
  always_ff @(posedge clock) begin
    if (!resetb || clr_i) pend <= '0;
    else begin
      for (int k = 0; k < NCH; k++) begin
        if (chg[k])       pend[k] <= 1'b1;
        else if (pick[k]) pend[k] <= 1'b0;
      end
    end
  end

  // Latched stage code per pending channel (data only, no reset needed).
  always_ff @(posedge clock) begin
    for (int k = 0; k < NCH; k++)
      if (chg[k]) pend_s[k] <= stage_i[k*SW +: SW];
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && evt.evt_ready_i;
  assign wr    = push && (!full || pop);

  // FIFO pointers and sticky overflow; a pop frees the slot for a same-cycle push.
  always_ff @(posedge clock) begin
    if (!resetb || clr_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr)          wr_ptr <= wr_ptr + 1'b1;
      if (pop)         rd_ptr <= rd_ptr + 1'b1;
      if (push && !wr) ovf    <= 1'b1;
    end
  end

  // FIFO storage write.
  always_ff @(posedge clock) begin
    if (wr) mem[wr_ptr[AW-1:0]] <= push_d;
  end

  assign evt.evt_valid_o    = !empty;
  assign evt.evt_data_o     = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign evt.evt_overflow_o = ovf;
`else
  logic unused_log;
  assign unused_log         = ^{chg, evt.evt_ready_i};
  assign evt.evt_valid_o    = 1'b0;
  assign evt.evt_data_o     = '0;
  assign evt.evt_overflow_o = 1'b0;
`endif
endmodule

// File: tb/tb_stage_monitor.sv
// Randomized + directed bench for stage_monitor against a queue-based reference
// model of the channel rules and the event FIFO.
module tb_stage_monitor;
  localparam int NCH = 2, SW = 8, SAMPLE = 4, TIMEOUT = 5, DEPTH = 4;
  localparam int CW = 1, DW = CW + SW;

  logic              clock = 1'b0;
  logic              resetb = 1'b0;
  logic              clr_i = 1'b0;
  logic [NCH*SW-1:0] stage_i = '0;
  logic [NCH-1:0]    err_i = '0;
  logic [NCH*3-1:0]  ch_state_o;
  logic              all_done_o, all_pass_o;

  stage_monitor_if #(.DW(DW)) evt();

  stage_monitor #(
    .NCH(NCH), .SW(SW), .SAMPLE(SAMPLE), .TIMEOUT(TIMEOUT),
    .START_CODE(8'hFF), .PASS_CODE(8'hFE), .DEPTH(DEPTH)
  ) dut (
    .clock(clock), .resetb(resetb), .stage_i(stage_i), .err_i(err_i), .clr_i(clr_i),
    .ch_state_o(ch_state_o), .all_done_o(all_done_o), .all_pass_o(all_pass_o), .evt(evt)
  );

  always #5 clock = ~clock;

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // States: 0 IDLE, 1 RUN, 2 PASS, 3 FAIL, 4 TIMEOUT
  int            m_st [NCH];
  logic [SW-1:0] m_last [NCH];
  int            m_tmr [NCH];
  int            m_cnt = 0;
  logic [DW-1:0] m_q [$];
  logic [DW-1:0] m_pend [$];
  bit            m_ovf = 0;
  bit            m_pop, m_full;
  logic [SW-1:0] ms;
  logic [DW-1:0] md;

  initial for (int k = 0; k < NCH; k++) begin m_st[k] = 0; m_last[k] = '0; m_tmr[k] = 0; end

  always @(posedge clock) begin
    if (!resetb || clr_i) begin
      for (int k = 0; k < NCH; k++) begin m_st[k] = 0; m_last[k] = '0; m_tmr[k] = 0; end
      m_cnt = 0; m_ovf = 0;
      m_q.delete(); m_pend.delete();
    end else begin
`ifdef STAGE_MONITOR_LOG_EN
      m_pop  = (m_q.size() > 0) && evt.evt_ready_i;
      m_full = (m_q.size() == DEPTH);
      if (m_pop) void'(m_q.pop_front());
      if (m_pend.size() > 0) begin
        md = m_pend.pop_front();
        if (!m_full || m_pop) m_q.push_back(md);
        else m_ovf = 1;
      end
`endif
      if (m_cnt == SAMPLE - 1) begin
        for (int k = 0; k < NCH; k++) begin
          ms = stage_i[k*SW +: SW];
          if (m_st[k] == 0) begin
            if (ms == 8'hFF) begin m_st[k] = 1; m_tmr[k] = 0; end
          end else if (m_st[k] == 1) begin
            if (err_i[k])             m_st[k] = 3;
            else if (ms == 8'hFE)     m_st[k] = 2;
            else if (ms != m_last[k]) m_tmr[k] = 0;
            else begin
              m_tmr[k]++;
              if (m_tmr[k] == TIMEOUT) m_st[k] = 4;
            end
          end
          if (ms != m_last[k]) m_pend.push_back({CW'(k), ms});
          m_last[k] = ms;
        end
      end
      m_cnt = (m_cnt + 1) % SAMPLE;
    end
  end

  // ---------------- continuous comparison ----------------
  logic [NCH*3-1:0] e_st;
  bit               e_done, e_pass, e_valid, e_ovf;
  logic [DW-1:0]    e_data;
  logic [DW-1:0]    obs [$];

  always @(negedge clock) begin
    e_st = '0; e_done = 1; e_pass = 1;
    for (int k = 0; k < NCH; k++) begin
      e_st[k*3 +: 3] = 3'(m_st[k]);
      if (m_st[k] < 2)  e_done = 0;
      if (m_st[k] != 2) e_pass = 0;
    end
`ifdef STAGE_MONITOR_LOG_EN
    e_valid = (m_q.size() > 0);
    e_data  = e_valid ? m_q[0] : '0;
    e_ovf   = m_ovf;
`else
    e_valid = 0; e_data = '0; e_ovf = 0;
`endif
    chk("ch_state", 32'(ch_state_o), 32'(e_st));
    chk("all_done", 32'(all_done_o), 32'(e_done));
    chk("all_pass", 32'(all_pass_o), 32'(e_pass));
    chk("evt_valid", 32'(evt.evt_valid_o), 32'(e_valid));
    chk("evt_data", 32'(evt.evt_data_o), 32'(e_data));
    chk("evt_ovf", 32'(evt.evt_overflow_o), 32'(e_ovf));
    if (evt.evt_valid_o && evt.evt_ready_i) obs.push_back(evt.evt_data_o);
  end

  // ---------------- stimulus ----------------
  logic [SW-1:0] codes [4] = '{8'hFF, 8'h01, 8'h02, 8'hFE};
  logic [SW-1:0] pool  [6] = '{8'hFF, 8'hFE, 8'h00, 8'h01, 8'h02, 8'h03};

  task automatic tick(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic strobe_in(input logic [SW-1:0] s0, input logic [SW-1:0] s1, input logic [1:0] e);
    stage_i = {s1, s0};
    err_i   = e;
    tick(SAMPLE);
  endtask

  task automatic do_clr();
    clr_i = 1'b1;
    tick(1);
    clr_i = 1'b0;
  endtask

  initial begin
    evt.evt_ready_i = 1'b1;
    tick(3);
    chk("rst_state", 32'(ch_state_o), 0);
    chk("rst_valid", 32'(evt.evt_valid_o), 0);
    chk("rst_data", 32'(evt.evt_data_o), 0);
    chk("rst_ovf", 32'(evt.evt_overflow_o), 0);
    resetb = 1'b1;

    // Pass path on both channels
    stage_i = '0; do_clr(); obs.delete();
    for (int i = 0; i < 4; i++) strobe_in(codes[i], codes[i], 2'b00);
    tick(SAMPLE);
    chk("pass_ch0", 32'(ch_state_o[2:0]), 2);
    chk("pass_ch1", 32'(ch_state_o[5:3]), 2);
    chk("pass_done", 32'(all_done_o), 1);
    chk("pass_all", 32'(all_pass_o), 1);
`ifdef STAGE_MONITOR_LOG_EN
    chk("pass_nevt", obs.size(), 8);
    for (int i = 0; i < 8 && i < obs.size(); i++)
      chk("pass_evt", 32'(obs[i]), 32'({CW'(i % 2), codes[i / 2]}));
`else
    chk("nolog_nevt", obs.size(), 0);
`endif

    // Timeout: arm, change to 03, then 5 unchanged strobes
    stage_i = '0; err_i = '0; do_clr();
    strobe_in(8'hFF, 8'h00, 2'b00);
    strobe_in(8'h03, 8'h00, 2'b00);
    for (int i = 0; i < 4; i++) strobe_in(8'h03, 8'h00, 2'b00);
    chk("tmo_early", 32'(ch_state_o[2:0]), 1);
    strobe_in(8'h03, 8'h00, 2'b00);
    chk("tmo", 32'(ch_state_o[2:0]), 4);
    chk("tmo_ch1", 32'(ch_state_o[5:3]), 0);

    // Error priority
    stage_i = '0; do_clr();
    strobe_in(8'h00, 8'h00, 2'b10);
    chk("err_idle", 32'(ch_state_o[5:3]), 0);
    strobe_in(8'h00, 8'hFF, 2'b00);
    chk("err_run", 32'(ch_state_o[5:3]), 1);
    strobe_in(8'h00, 8'hFE, 2'b10);
    chk("err_fail", 32'(ch_state_o[5:3]), 3);
    err_i = '0;

    // Overflow
    evt.evt_ready_i = 1'b0; stage_i = '0; do_clr(); obs.delete();
    for (int i = 1; i <= 5; i++) strobe_in(8'(i), 8'h00, 2'b00);
    tick(2);
`ifdef STAGE_MONITOR_LOG_EN
    chk("ovf_flag", 32'(evt.evt_overflow_o), 1);
    chk("ovf_valid", 32'(evt.evt_valid_o), 1);
    evt.evt_ready_i = 1'b1;
    tick(8);
    chk("ovf_npop", obs.size(), 4);
    for (int i = 0; i < 4 && i < obs.size(); i++)
      chk("ovf_pop", 32'(obs[i]), 32'({1'b0, 8'(i + 1)}));
    chk("ovf_sticky", 32'(evt.evt_overflow_o), 1);
    do_clr();
    chk("ovf_clr", 32'(evt.evt_overflow_o), 0);
`else
    chk("nolog_ovf", 32'(evt.evt_overflow_o), 0);
    evt.evt_ready_i = 1'b1;
`endif

    // Clear mid-drain
    evt.evt_ready_i = 1'b1; stage_i = '0; do_clr(); obs.delete();
    stage_i = {8'h11, 8'h22};
    tick(SAMPLE);
    stage_i = '0; clr_i = 1'b1; tick(1); clr_i = 1'b0;
    tick(3 * SAMPLE);
    chk("mid_nevt", obs.size(), 0);
    chk("mid_state", 32'(ch_state_o), 0);
    chk("mid_valid", 32'(evt.evt_valid_o), 0);

    // Randomized phase, checked cycle by cycle against the model
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NCH; k++)
        if ($urandom_range(0, 15) == 0) stage_i[k*SW +: SW] = pool[$urandom_range(0, 5)];
      err_i           = ($urandom_range(0, 23) == 0) ? NCH'($urandom_range(1, 3)) : '0;
      evt.evt_ready_i = ($urandom_range(0, 9) < 6);
      clr_i           = ($urandom_range(0, 199) == 0);
      resetb          = ($urandom_range(0, 499) != 0);
      tick(1);
    end
    clr_i = 1'b0; resetb = 1'b1;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/stage_monitor.md
# stage_monitor

Synthesizable, parametrised test-stage monitor for the user project area. Each of `NCH` channels presents a stage code and an error flag. The monitor samples them on a fixed prescaled interval and tracks each channel through start, run, pass, fail and timeout. Stage transitions go into an event FIFO that the management core (or a debug UART bridge) drains through a valid/ready port, so the on-chip pass/fail verdict matches the one the DV benches already use.

## Interface
Parameters:
- `NCH`, 2: number of monitored channels (1..8).
- `SW`, 8: stage code width.
- `SAMPLE`, 100: clocks per sample strobe; must be ≥ `NCH`+2.
- `TIMEOUT`, 24000: consecutive unchanged samples in RUN before the channel times out.
- `START_CODE`, 8'hFF: stage code that arms a channel.
- `PASS_CODE`, 8'hFE: stage code that signals pass.
- `DEPTH`, 8: event FIFO depth; must be a power of 2 and ≥ 2.

Ports (`CW` = `NCH`>1 ? clog2(`NCH`) : 1):
- `clock`  in  1  — single clock.
- `resetb`  in  1  — synchronous, active-low reset.
- `stage_i`  in  `NCH`*`SW`  — channel k stage code at bits [k*SW +: SW].
- `err_i`  in  `NCH`  — per-channel error flag.
- `clr_i`  in  1  — synchronous clear of all monitor state.
- `ch_state_o`  out  `NCH`*3  — per-channel state: 0 IDLE, 1 RUN, 2 PASS, 3 FAIL, 4 TIMEOUT.
- `all_done_o`  out  1  — every channel is in PASS, FAIL or TIMEOUT.
- `all_pass_o`  out  1  — every channel is in PASS.
- `evt_valid_o`  out  1  — FIFO head is valid.
- `evt_ready_i`  in  1  — consumer pops the head.
- `evt_data_o`  out  `CW`+`SW`  — {channel id, stage code}.
- `evt_overflow_o`  out  1  — sticky flag: an event was dropped.

## Operation
- Prescaler counts 0..`SAMPLE`-1 and wraps. The strobe fires in the cycle where count = `SAMPLE`-1.
- Per channel, evaluated only on a strobe, using the sampled stage `s` and the stored `last`:
  - IDLE: if `s`==`START_CODE`, go to RUN and clear the timer. `err_i` is ignored in IDLE.
  - RUN, checks in priority order:
    - `err_i` high → FAIL.
    - `s`==`PASS_CODE` → PASS.
    - `s`≠`last` → clear the timer.
    - otherwise increment the timer; when the incremented value = `TIMEOUT` → TIMEOUT.
  - PASS, FAIL and TIMEOUT are terminal until `clr_i` or reset.
  - `last` ← `s` on every strobe, in every state.
- Event logging: on a strobe where `s`≠`last`, in any state, the channel sets a pending bit and latches `s`.
  - Pending entries are pushed one per cycle, lowest channel index first.
  - `SAMPLE` ≥ `NCH`+2 guarantees all pending entries drain before the next strobe.
- FIFO:
  - Push when full and no pop in that cycle → entry dropped, `evt_overflow_o` set.
  - Push and pop in the same cycle while full → both accepted; occupancy unchanged.
  - Pop when empty → no effect.
- `clr_i` (beneath reset, above everything else): all channels to IDLE; clears `last`, timers, pending bits, prescaler, FIFO and overflow.
- `all_done_o` and `all_pass_o` decode the state registers combinationally.

## Timing
- Reset values: `ch_state_o`=0, `all_done_o`=0, `all_pass_o`=0, `evt_valid_o`=0, `evt_data_o`=0, `evt_overflow_o`=0, prescaler=0, `last`=0, timers=0.
- State latency: `ch_state_o` changes on the clock edge that ends the strobe cycle.
- Event latency: the pending bit for channel k is set on that same edge. Its entry is pushed on the (r+1)-th following edge, where r = number of lower-index pending channels. `evt_valid_o` rises on that push edge.
- Handshake: a pop occurs on a rising edge with `evt_valid_o` && `evt_ready_i`. `evt_data_o` stays stable while valid and not popped.
- Reset or `clr_i` asserted mid-drain discards pending and queued events in that cycle.

## Configuration
- `STAGE_MONITOR_LOG_EN` defined: pending logic and event FIFO are present, as described above.
- `STAGE_MONITOR_LOG_EN` undefined: no FIFO or pending logic. `evt_valid_o`, `evt_data_o` and `evt_overflow_o` are tied 0 and `evt_ready_i` is ignored. State tracking is unchanged.

## Test plan
Bench parameters: `NCH`=2, `SAMPLE`=4, `TIMEOUT`=5, `DEPTH`=4, with `STAGE_MONITOR_LOG_EN` defined unless noted.
- Pass path: ch0 stage sequence FF, 01, 02, FE, one value per strobe; ch1 driven through the same sequence.
  - Both channels reach PASS; `all_done_o`=`all_pass_o`=1.
  - 8 events delivered in order ch0 then ch1 per strobe: {0,FF},{1,FF},{0,01},{1,01},…
- Timeout: ch0 armed with FF, then held at 03 for 5 strobes → ch0=4 (TIMEOUT) after the 5th unchanged strobe, not earlier.
- Error priority: ch1 in RUN, `err_i`[1]=1 on the same strobe as stage FE → ch1=3 (FAIL). An `err_i` pulse while ch1 is IDLE causes no state change.
- Overflow: `evt_ready_i`=0, ch0 stage changed on 5 consecutive strobes → 4 entries retained, `evt_overflow_o`=1. Then `evt_ready_i`=1 → 4 pops with the original data; overflow stays 1 until `clr_i`.
- Clear mid-drain: assert `clr_i` one cycle after a strobe with both channels pending → FIFO empty, both channels IDLE, no event emitted afterwards.
- Logging disabled (`STAGE_MONITOR_LOG_EN` undefined): rerun the pass path → same states reached; `evt_valid_o` stays 0 throughout.
